// File: rtl/accumulator_pkg.sv
// Shared types and constants for the stream accumulator.
package accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

  // Fill bit for clearing datapath registers; replicate to the target width.
  localparam bit ACC_CLEAR = '0;

endpackage

// File: rtl/adder_nbit.sv
// SIZE-bit ripple-carry adder built from full_adder cells.
module adder_nbit #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            carry_in,
  output logic [SIZE-1:0] sum,
  output logic            carry_out
);

  logic [SIZE:0] carry;

  assign carry[0]  = carry_in;
  assign carry_out = carry[SIZE];

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    full_adder u_fa (
      .a         (a[i]),
      .b         (b[i]),
      .carry_in  (carry[i]),
      .sum       (sum[i]),
      .carry_out (carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/accumulator_nbit.sv
// Stream accumulator: sums a programmed number of unsigned samples taken
// over a valid/ready handshake, reporting the sum, a sticky overflow flag
// and a one-cycle done pulse.
// Optional build macro: ACCUM_SATURATE_EN (saturate acc_out on carry).
module accumulator_nbit
  import accumulator_pkg::*;
#(
  parameter int SIZE    = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_samples,
  input  logic               in_valid,
  input  logic [SIZE-1:0]    in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [SIZE-1:0]    acc_out,
  output logic               overflow,
  output logic [COUNT_W-1:0] sample_count
);

  acc_state_t         state;
  acc_state_t         state_nxt;
  logic [COUNT_W-1:0] num_lat;
  logic [SIZE-1:0]    sum;
  logic               carry_out;
  logic [SIZE-1:0]    acc_nxt;
  logic               beat;
  logic               start_acc;

  adder_nbit #(.SIZE(SIZE)) u_add (
    .a         (acc_out),
    .b         (in_data),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry_out)
  );

`ifdef ACCUM_SATURATE_EN
  // Once all-ones, any further non-zero sample carries again, so the
  // value stays pinned for the rest of the run without extra state.
  assign acc_nxt = carry_out ? '1 : sum;
`else
  assign acc_nxt = sum;
`endif

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    beat      = 1'b0;
    start_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = (num_samples == {COUNT_W{ACC_CLEAR}}) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        beat     = in_valid;
        if (in_valid && (sample_count + COUNT_W'(1) == num_lat)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and accumulator datapath registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      acc_out      <= {SIZE{ACC_CLEAR}};
      overflow     <= 1'b0;
      sample_count <= {COUNT_W{ACC_CLEAR}};
      num_lat      <= {COUNT_W{ACC_CLEAR}};
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        acc_out      <= {SIZE{ACC_CLEAR}};
        overflow     <= 1'b0;
        sample_count <= {COUNT_W{ACC_CLEAR}};
        num_lat      <= num_samples;
      end else if (beat) begin
        acc_out      <= acc_nxt;
        overflow     <= overflow | carry_out;
        sample_count <= sample_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accumulator_nbit.sv
// Self-checking bench for accumulator_nbit: directed scenarios plus random
// runs compared against an unbounded-integer model of the running sum.
module tb_accumulator_nbit;

  localparam int SIZE    = 16;
  localparam int COUNT_W = 8;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               start;
  logic [COUNT_W-1:0] num_samples;
  logic               in_valid;
  logic [SIZE-1:0]    in_data;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [SIZE-1:0]    acc_out;
  logic               overflow;
  logic [COUNT_W-1:0] sample_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [SIZE-1:0] samples [$];

  accumulator_nbit #(.SIZE(SIZE), .COUNT_W(COUNT_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .acc_out      (acc_out),
    .overflow     (overflow),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected accumulator value from the true (unbounded) sum of samples.
  function automatic logic [SIZE-1:0] exp_acc(input longint total);
`ifdef ACCUM_SATURATE_EN
    if (total >= (longint'(1) << SIZE)) return '1;
    return SIZE'(total);
`else
    return SIZE'(total);
`endif
  endfunction

  function automatic logic exp_ovf(input longint total);
    return total >= (longint'(1) << SIZE);
  endfunction

  function automatic logic [SIZE-1:0] rand_sample;
    if ($urandom_range(0, 3) == 0) return SIZE'($urandom_range(0, 65535));
    return SIZE'($urandom_range(0, 300));
  endfunction

  // One complete run using the first n entries of samples[].
  task automatic run(input int n, input int gap_pct, input bit poke_start);
    longint total  = 0;
    int     idx    = 0;
    int     cycles = 0;
    bit     v;
    start       = 1'b1;
    num_samples = COUNT_W'(n);
    tick;
    start = 1'b0;
    if (n == 0) begin
      check("zero_done", done, 1);
      check("zero_ready", in_ready, 0);
      check("zero_acc", acc_out, 0);
    end else begin
      while (idx < n && cycles < n * 4 + 50) begin
        check("run_ready", in_ready, 1);
        check("run_busy", busy, 1);
        check("run_nodone", done, 0);
        check("run_acc", acc_out, exp_acc(total));
        check("run_cnt", sample_count, idx);
        check("run_ovf", overflow, exp_ovf(total));
        v = ($urandom_range(0, 99) >= gap_pct);
        in_valid = v;
        in_data  = v ? samples[idx] : SIZE'($urandom);
        if (poke_start) begin
          start       = $urandom_range(0, 1) == 1;
          num_samples = COUNT_W'($urandom);
        end
        tick;
        cycles++;
        if (v) begin
          total += longint'(samples[idx]);
          idx++;
        end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (idx < n) check("beat_timeout", idx, n);
      check("done_pulse", done, 1);
      check("done_ready", in_ready, 0);
    end
    check("done_acc", acc_out, exp_acc(total));
    check("done_ovf", overflow, exp_ovf(total));
    check("done_cnt", sample_count, idx);
    // Offer a sample and a start during the DONE cycle; both must be ignored.
    in_valid    = 1'b1;
    in_data     = SIZE'($urandom);
    start       = 1'b1;
    num_samples = COUNT_W'($urandom_range(1, 255));
    tick;
    in_valid = 1'b0;
    start    = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_ready", in_ready, 0);
    check("post_acc", acc_out, exp_acc(total));
    check("post_cnt", sample_count, idx);
    tick;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_acc", acc_out, exp_acc(total));
    check("idle_ovf", overflow, exp_ovf(total));
  endtask

  initial begin
    n_rst       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    tick;
    tick;
    check("rst_acc", acc_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", sample_count, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    n_rst = 1'b1;
    tick;

    samples = {16'd10, 16'd20, 16'd30};
    run(3, 0, 1'b0);

    samples = {16'hFFF0, 16'h0020};
    run(2, 0, 1'b0);
`ifdef ACCUM_SATURATE_EN
    check("wrap_const", acc_out, 16'hFFFF);
`else
    check("wrap_const", acc_out, 16'h0010);
`endif
    check("wrap_ovf_const", overflow, 1);

    run(0, 0, 1'b0);

    samples = {16'd5, 16'd7, 16'd11, 16'd13};
    run(4, 50, 1'b1);
    check("gap_sum_const", acc_out, 36);

    // Abort mid-run with reset after two of five beats.
    samples = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    start       = 1'b1;
    num_samples = 8'd5;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = samples[i];
      tick;
    end
    in_valid = 1'b0;
    check("pre_abort_acc", acc_out, 3);
    n_rst = 1'b0;
    tick;
    check("abort_acc", acc_out, 0);
    check("abort_cnt", sample_count, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 0);
    n_rst = 1'b1;
    tick;
    check("abort_nodone", done, 0);
    check("abort_idle", busy, 0);
    run(5, 20, 1'b0);

    samples = {};
    for (int i = 0; i < 255; i++) samples.push_back(SIZE'($urandom_range(0, 255)));
    run(255, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 12);
      samples = {};
      for (int i = 0; i < n; i++) samples.push_back(rand_sample());
      run(n, $urandom_range(0, 60), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
